// File: rtl/cl_sde_img_stream_if.sv
// cl_sde_img_stream_if: valid/ready stream bundle used for the four data ports of cl_sde_img_stream.
interface cl_sde_img_stream_if #(parameter int W = 512);
   logic           valid;
   logic           ready;
   logic [W-1:0]   data;
   logic [W/8-1:0] keep;
   logic           last;
   modport master (output valid, data, keep, last, input ready);
   modport slave  (input valid, data, keep, last, output ready);
endinterface

// File: rtl/cl_sde_img_stream.sv
// cl_sde_img_stream: buffers whole images for an NN engine and serialises its results to the output stream.
// Optional feature: define SDE_IMG_LATENCY_EN for start-to-result latency CSRs (LAT_LAST/LAT_MAX).
module cl_sde_img_stream #(
   parameter int IN_W      = 512,
   parameter int PIX_W     = 64,
   parameter int IMG_BEATS = 1024,
   parameter int IN_DEPTH  = 256,
   parameter int RES_W     = 1024,
   parameter int OUT_W     = 160,
   parameter int NUM_OUT   = 1,
   parameter int OUT_DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [11:0]                cfg_addr,
   input  logic                       cfg_wr,
   input  logic                       cfg_rd,
   input  logic [31:0]                cfg_wdata,
   output logic                       cfg_ack,
   output logic [31:0]                cfg_rdata,
   cl_sde_img_stream_if.slave         ins,
   cl_sde_img_stream_if.master        eng_in,
   cl_sde_img_stream_if.slave         eng_out,
   cl_sde_img_stream_if.master        ots
);
   localparam int IMG_WORDS = IMG_BEATS * PIX_W / IN_W;
   localparam int SUBS = IN_W / PIX_W;
   localparam int SW = SUBS > 1 ? $clog2(SUBS) : 1;
   localparam int IAW = $clog2(IN_DEPTH);
   localparam int OAW = $clog2(OUT_DEPTH);
   localparam int BW = $clog2(IMG_BEATS + 1);
   localparam int NW = $clog2(NUM_OUT + 1);
   localparam logic [IN_W/8-1:0] KEEP = (IN_W/8)'({(OUT_W/8){1'b1}});
   typedef enum logic {IDLE, STREAM} state_t;
   state_t state_q, state_d;
   logic [IN_W-1:0] imem [IN_DEPTH];
   logic [IAW:0] iwp, irp, ifill;
   logic [IN_W-1:0] iword;
   logic [SW-1:0] sub;
   logic [BW-1:0] bcnt;
   logic ipush, ipop, beat_acc, start, done;
   logic [OUT_W:0] omem [OUT_DEPTH];
   logic [OAW:0] owp, orp, ofill;
   logic [OUT_W:0] oword;
   logic [RES_W-1:0] res_q;
   logic [NW-1:0] scnt;
   logic cap, opush, opop;
   logic en, clr;
   logic [31:0] n_img, n_res, n_words, lat_last, lat_max, rd_mux;
   assign ifill = iwp - irp;
   assign ins.ready = ifill != (IAW+1)'(IN_DEPTH);
   assign ipush = ins.valid & ins.ready;
   assign iword = imem[irp[IAW-1:0]];
   assign beat_acc = eng_in.valid & eng_in.ready;
   assign ipop = beat_acc && sub == SW'(SUBS - 1);
   assign start = state_q == IDLE && en && ifill >= (IAW+1)'(IMG_WORDS);
   assign done = beat_acc && bcnt == BW'(1);
   always_comb state_d = start ? STREAM : done ? IDLE : state_q;
   assign eng_in.valid = state_q == STREAM;
   assign eng_in.data = eng_in.valid ? iword[sub*PIX_W +: PIX_W] : '0;
   assign eng_in.keep = '0;
   assign eng_in.last = eng_in.valid && bcnt == BW'(1);
   // accept a result only when the FIFO already has room for every word it will produce
   assign ofill = owp - orp;
   assign eng_out.ready = scnt == '0 && ofill <= (OAW+1)'(OUT_DEPTH - NUM_OUT);
   assign cap = eng_out.valid & eng_out.ready;
   assign opush = scnt != '0;
   assign opop = ots.valid & ots.ready;
   assign oword = omem[orp[OAW-1:0]];
   assign ots.valid = ofill != '0;
   assign ots.data = ots.valid ? IN_W'(oword[OUT_W-1:0]) : '0;
   assign ots.keep = ots.valid ? KEEP : '0;
   assign ots.last = ots.valid & oword[OUT_W];
   assign clr = cfg_wr && cfg_addr == 12'h000 && cfg_wdata[1];
   always_ff @(posedge clk) if (ipush) imem[iwp[IAW-1:0]] <= ins.data;
   always_ff @(posedge clk) if (opush) omem[owp[OAW-1:0]] <= {scnt == NW'(1), res_q[RES_W-1 -: OUT_W]};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= IDLE;
         iwp       <= '0;
         irp       <= '0;
         sub       <= '0;
         bcnt      <= '0;
         res_q     <= '0;
         scnt      <= '0;
         owp       <= '0;
         orp       <= '0;
         en        <= 1'b0;
         n_img     <= '0;
         n_res     <= '0;
         n_words   <= '0;
         cfg_ack   <= 1'b0;
         cfg_rdata <= '0;
      end else begin
         state_q   <= state_d;
         iwp       <= iwp + (IAW+1)'(ipush);
         irp       <= irp + (IAW+1)'(ipop);
         sub       <= !beat_acc ? sub : sub == SW'(SUBS - 1) ? '0 : sub + SW'(1);
         bcnt      <= start ? BW'(IMG_BEATS) : bcnt - BW'(beat_acc);
         res_q     <= cap ? eng_out.data : opush ? res_q << OUT_W : res_q;
         scnt      <= cap ? NW'(NUM_OUT) : scnt - NW'(opush);
         owp       <= owp + (OAW+1)'(opush);
         orp       <= orp + (OAW+1)'(opop);
         en        <= cfg_wr && cfg_addr == 12'h000 ? cfg_wdata[0] : en;
         n_img     <= clr ? '0 : n_img + 32'(start);
         n_res     <= clr ? '0 : n_res + 32'(cap);
         n_words   <= clr ? '0 : n_words + 32'(opop);
         cfg_ack   <= cfg_wr | cfg_rd;
         cfg_rdata <= cfg_rd && !cfg_wr ? rd_mux : '0;
      end
`ifdef SDE_IMG_LATENCY_EN
   logic [31:0] lat_cnt;
   logic lat_busy;
   // counter idles at 1 so the first STREAM cycle already reads one elapsed cycle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         lat_cnt  <= 32'd1;
         lat_busy <= 1'b0;
         lat_last <= '0;
         lat_max  <= '0;
      end else begin
         lat_busy <= lat_busy ? !cap : start;
         lat_cnt  <= !lat_busy ? 32'd1 : lat_cnt == '1 ? lat_cnt : lat_cnt + 32'd1;
         lat_last <= clr ? '0 : cap && lat_busy ? lat_cnt : lat_last;
         lat_max  <= clr ? '0 : cap && lat_busy && lat_cnt > lat_max ? lat_cnt : lat_max;
      end
`else
   assign lat_last = '0;
   assign lat_max = '0;
`endif
   always_comb begin
      rd_mux = '0;
      case (cfg_addr)
         12'h000: rd_mux = {31'd0, en};
         12'h004: rd_mux = {28'd0, ofill == (OAW+1)'(OUT_DEPTH), ofill == '0, ifill == '0, state_q == STREAM};
         12'h008: rd_mux = 32'(ifill);
         12'h010: rd_mux = n_img;
         12'h014: rd_mux = n_res;
         12'h018: rd_mux = n_words;
         12'h020: rd_mux = lat_last;
         12'h024: rd_mux = lat_max;
         default: rd_mux = '0;
      endcase
   end
endmodule

// File: tb/tb_cl_sde_img_stream.sv
// tb_cl_sde_img_stream: directed bench for cl_sde_img_stream built with NUM_OUT=3, other parameters default.
module tb_cl_sde_img_stream;
   localparam int IMG_BEATS = 1024;
`ifdef SDE_IMG_LATENCY_EN
   localparam logic [31:0] LAT_EXP = 32'd2000;
`else
   localparam logic [31:0] LAT_EXP = 32'd0;
`endif
   localparam logic [159:0] W0 = 160'h0000001f_0000001e_0000001d_0000001c_0000001b;
   localparam logic [159:0] W1 = 160'h0000001a_00000019_00000018_00000017_00000016;
   localparam logic [159:0] W2 = 160'h00000015_00000014_00000013_00000012_00000011;
   localparam logic [63:0] KEEP_EXP = 64'h0000_0000_000f_ffff;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [11:0] cfg_addr = '0;
   logic cfg_wr = 1'b0;
   logic cfg_rd = 1'b0;
   logic [31:0] cfg_wdata = '0;
   logic cfg_ack;
   logic [31:0] cfg_rdata;
   int n_chk = 0;
   int n_pass = 0;
   cl_sde_img_stream_if #(512) ins();
   cl_sde_img_stream_if #(64) eng_in();
   cl_sde_img_stream_if #(1024) eng_out();
   cl_sde_img_stream_if #(512) ots();
   cl_sde_img_stream #(.NUM_OUT(3)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_addr(cfg_addr), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
      .cfg_wdata(cfg_wdata), .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata),
      .ins(ins), .eng_in(eng_in), .eng_out(eng_out), .ots(ots)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask
   function automatic logic [511:0] mk(input int tag, input int w);
      logic [511:0] r;
      for (int j = 0; j < 8; j++) r[64*j +: 64] = {32'(tag), 16'(w), 16'(j)};
      return r;
   endfunction
   task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
      cfg_addr = a;
      cfg_wdata = d;
      cfg_wr = 1'b1;
      @(negedge clk);
      cfg_wr = 1'b0;
   endtask
   task automatic csr_rd(input string tag, input logic [11:0] a, input logic [31:0] e);
      cfg_addr = a;
      cfg_rd = 1'b1;
      @(negedge clk);
      cfg_rd = 1'b0;
      chk({tag, "_ack"}, cfg_ack, 1);
      chk(tag, cfg_rdata, e);
   endtask
   task automatic push(input int tag, input int n);
      int w = 0;
      for (int g = 0; g < 5000 && w < n; g++) begin
         ins.valid = 1'b1;
         ins.data = mk(tag, w);
         if (ins.ready) w++;
         @(negedge clk);
      end
      ins.valid = 1'b0;
      chk("push_cnt", w, n);
   endtask
   task automatic recv(input int tag, input int wb, input bit tog);
      int b = 0;
      bit held = 1'b0;
      logic [63:0] hv = '0;
      for (int g = 0; g < 5000 && b < IMG_BEATS; g++) begin
         eng_in.ready = tog ? g[0] : 1'b1;
         if (held) chk("stall_hold", eng_in.data, hv);
         held = eng_in.valid && !eng_in.ready;
         hv = eng_in.data;
         if (eng_in.valid && eng_in.ready) begin
            chk("beat", eng_in.data, {32'(tag), 16'(wb + b / 8), 16'(b % 8)});
            b++;
         end
         @(negedge clk);
      end
      eng_in.ready = 1'b0;
      chk("beat_cnt", b, IMG_BEATS);
      chk("post_idle", eng_in.valid, 0);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
   initial begin
      logic [1023:0] pat;
      int k;
      bit capd;
      ins.valid = 1'b0; ins.data = '0; ins.keep = '0; ins.last = 1'b0;
      eng_in.ready = 1'b0;
      eng_out.valid = 1'b0; eng_out.data = '0; eng_out.keep = '0; eng_out.last = 1'b0;
      ots.ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ins_ready", ins.ready, 1);
      chk("rst_eng_in_valid", eng_in.valid, 0);
      chk("rst_eng_in_data", eng_in.data, 0);
      chk("rst_eng_out_ready", eng_out.ready, 1);
      chk("rst_ots_valid", ots.valid, 0);
      chk("rst_ots_data", ots.data, 0);
      chk("rst_ots_keep", ots.keep, 0);
      chk("rst_ots_last", ots.last, 0);
      chk("rst_cfg_ack", cfg_ack, 0);
      chk("rst_cfg_rdata", cfg_rdata, 0);
      rst_n = 1'b1;
      @(negedge clk);
      // image held back while disabled, then released
      push(1, 128);
      repeat (5) @(negedge clk);
      chk("en0_no_valid", eng_in.valid, 0);
      csr_rd("in_fill_128", 12'h008, 128);
      csr_rd("status_idle", 12'h004, 4);
      csr_wr(12'h000, 1);
      recv(1, 0, 1'b0);
      csr_rd("images_1", 12'h010, 1);
      // 50% engine backpressure
      push(2, 128);
      recv(2, 0, 1'b1);
      // fill to 256 with the engine stalled, then two images back-to-back
      push(3, 256);
      chk("ins_ready_full", ins.ready, 0);
      csr_rd("in_fill_256", 12'h008, 256);
      csr_rd("status_full", 12'h004, 5);
      recv(3, 0, 1'b0);
      recv(3, 128, 1'b0);
      csr_rd("images_4", 12'h010, 4);
      csr_rd("in_fill_0", 12'h008, 0);
      // single result, MSB-first serialisation
      for (int i = 0; i < 32; i++) pat[32*i +: 32] = 32'(i);
      eng_out.valid = 1'b1;
      eng_out.data = pat;
      chk("res_ready", eng_out.ready, 1);
      @(negedge clk);
      eng_out.valid = 1'b0;
      chk("cap_lat1", ots.valid, 0);
      @(negedge clk);
      chk("cap_lat2", ots.valid, 1);
      chk("w0", ots.data, W0);
      chk("w0_last", ots.last, 0);
      chk("w0_keep", ots.keep, KEEP_EXP);
      @(negedge clk);
      chk("w0_hold", ots.data, W0);
      chk("w0_hold_last", ots.last, 0);
      ots.ready = 1'b1;
      @(negedge clk);
      chk("w1", ots.data, W1);
      chk("w1_last", ots.last, 0);
      @(negedge clk);
      chk("w2", ots.data, W2);
      chk("w2_last", ots.last, 1);
      chk("w2_keep", ots.keep, KEEP_EXP);
      @(negedge clk);
      chk("ots_drained", ots.valid, 0);
      csr_rd("results_1", 12'h014, 1);
      csr_rd("words_3", 12'h018, 3);
      // output backpressure: six results into a 16-word FIFO
      ots.ready = 1'b0;
      csr_wr(12'h000, 3);
      for (int r = 0; r < 5; r++) begin
         int g = 0;
         eng_out.valid = 1'b1;
         eng_out.data = {32{32'(r + 256)}};
         while (!eng_out.ready && g < 20) begin
            @(negedge clk);
            g++;
         end
         chk("res_acc", eng_out.ready, 1);
         @(negedge clk);
      end
      eng_out.valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("out_bp", eng_out.ready, 0);
      chk("out_not_full", ots.valid, 1);
      eng_out.valid = 1'b1;
      eng_out.data = {32{32'(5 + 256)}};
      ots.ready = 1'b1;
      k = 0;
      capd = 1'b0;
      for (int g = 0; g < 200 && k < 18; g++) begin
         if (ots.valid) begin
            chk("bp_word", ots.data, 512'({5{32'(k / 3 + 256)}}));
            chk("bp_last", ots.last, k % 3 == 2);
            k++;
         end
         if (capd) eng_out.valid = 1'b0;
         capd = eng_out.valid && eng_out.ready;
         @(negedge clk);
      end
      chk("bp_words", k, 18);
      chk("bp_r5_cap", eng_out.valid, 0);
      eng_out.valid = 1'b0;
      csr_rd("results_6", 12'h014, 6);
      csr_rd("words_18", 12'h018, 18);
      // latency: result returned 2000 cycles after the IDLE->STREAM transition
      csr_wr(12'h000, 3);
      eng_in.ready = 1'b1;
      push(6, 128);
      for (int g = 0; g < 50 && !eng_in.valid; g++) @(negedge clk);
      chk("lat_start", eng_in.valid, 1);
      repeat (1999) @(negedge clk);
      chk("lat_idle", eng_in.valid, 0);
      eng_out.valid = 1'b1;
      eng_out.data = pat;
      chk("lat_ready", eng_out.ready, 1);
      @(negedge clk);
      eng_out.valid = 1'b0;
      eng_in.ready = 1'b0;
      repeat (10) @(negedge clk);
      csr_rd("lat_last", 12'h020, LAT_EXP);
      csr_rd("lat_max", 12'h024, LAT_EXP);
      csr_rd("images_lat", 12'h010, 1);
      csr_wr(12'h000, 3);
      csr_rd("clr_images", 12'h010, 0);
      csr_rd("clr_results", 12'h014, 0);
      csr_rd("clr_words", 12'h018, 0);
      csr_rd("clr_lat_last", 12'h020, 0);
      csr_rd("clr_lat_max", 12'h024, 0);
      csr_rd("ctrl_en", 12'h000, 1);
      csr_rd("unmapped", 12'h030, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
